dmem_store_buffer: RTL and testbench
====================================

Name: dmem_store_buffer

Overview:
- Sits between the core's data-memory port (addrData_DMEM / wrData_DMEM / MemWrite_DMEM / MemRead_DMEM / readData_DMEM) and a single-port, 64-bit-word data SRAM with an asynchronous read.
- Stores retire into a FIFO in one cycle and drain to the SRAM one per cycle, whenever the SRAM port is not needed for a load.
- Loads see the youngest buffered store to the same word (store-to-load forwarding), otherwise the SRAM contents, combinationally in the same cycle.

Parameters:
DEPTH, 4, number of store-buffer entries (power of 2, >=2)
XLEN, 64, data width
MEM_AW, 6, SRAM word-index width; word index = addr[MEM_AW+2:3]

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low (0 = reset)
addrData_DMEM  in  64  core byte address; bits [2:0] ignored
wrData_DMEM  in  XLEN  core store data
MemWrite_DMEM  in  1  store request
MemRead_DMEM  in  1  load request
readData_DMEM  out  XLEN  load data, combinational
stall_o  out  1  store not accepted this cycle; core holds its request
flush_i  in  1  fence: drain-only mode until the buffer is empty
empty_o  out  1  buffer holds no valid entries
mem_addr_o  out  MEM_AW  SRAM word index
mem_wdata_o  out  XLEN  SRAM write data
mem_we_o  out  1  SRAM write enable, sampled at posedge clk
mem_rdata_i  in  XLEN  SRAM asynchronous read data at mem_addr_o

Behaviour:
- State: entry arrays addr[DEPTH], data[DEPTH], valid[DEPTH]; head/tail pointers; count (0..DEPTH).
- Reset (rst=0 at posedge):
  - count=0, head=tail=0, all valid=0.
  - Outputs while rst=0: mem_we_o=0, stall_o=0, empty_o=1, readData_DMEM=mem_rdata_i.
- Store accept:
  - Condition: MemWrite_DMEM=1, count<DEPTH, flush_i=0.
  - Entry written at tail, tail++, same cycle. Store latency into buffer = 1 cycle.
- stall_o = MemWrite_DMEM & (count==DEPTH | flush_i).
  - Combinational; no accept in a stalled cycle, even if a drain frees an entry that cycle.
- Drain:
  - Condition: count>0 and the SRAM port is free (not (MemRead_DMEM & no buffer hit)).
  - mem_we_o=1, mem_addr_o=addr[head], mem_wdata_o=data[head]; head++ at posedge.
- Port arbitration: a load that misses the buffer owns the port.
  - mem_addr_o = load word index, mem_we_o=0, drain deferred.
  - A load that hits the buffer does not use the port, so the drain proceeds.
- Forwarding:
  - Compare load word index against all valid entries; the youngest match (closest to tail) wins.
  - readData_DMEM = match ? entry data : mem_rdata_i. Zero added latency.
- Count update: accept and drain in the same cycle leaves count unchanged; pointers wrap modulo DEPTH.
- Simultaneous MemRead and MemWrite: the store is accepted; the load returns the value from before this store.
- flush_i: blocks new accepts (stall_o asserted on any store) and keeps draining until count==0.
- empty_o = (count==0), registered-equivalent from state.
- Reset mid-drain: buffered stores are discarded, no SRAM write in the reset cycle.
- Idle (no request): mem_addr_o = addr[head] if count>0, else 0.

Optional Feature:
STBUF_COALESCE_EN
- Defined:
  - A store whose word index matches a valid entry overwrites that entry's data in place.
  - No allocation, tail and count unchanged, accepted even when count==DEPTH.
  - Exception: if the match is the head entry draining this cycle, allocate normally.
  - Invariant: at most one valid entry per word index.
- Undefined: every accepted store allocates a new entry; duplicates are allowed and forwarding picks the youngest.

Decomposition:
- Shared package dmem_pkg:
  - XLEN, default DEPTH/MEM_AW constants.
  - typedef sb_entry_t {logic valid; logic [MEM_AW-1:0] widx; logic [XLEN-1:0] data;}.
  - Function word_idx(addr) returning addr[MEM_AW+2:3].
- One sub-module: sb_fwd_match.
  - Combinational youngest-match priority search over DEPTH entries, given head/tail.
  - Outputs hit and data.
  - Separately testable; keeps the top-level as FIFO control plus arbitration.

Test Plan:
- Store 0x8 to addr 0, no load next cycle → mem_we_o=1 at widx 0 the following cycle; empty_o returns to 1; SRAM[0]=8.
- Store 0x8 to addr 0, then a load from addr 0 the next cycle while undrained → readData_DMEM=8 via forwarding; drain proceeds the same cycle.
- Stores 0x11 to addr 0x10 then 0x22 to addr 0x10 back-to-back; load 0x10 → 0x22 (youngest wins); with STBUF_COALESCE_EN, count=1 after the second store.
- DEPTH=4: five stores back-to-back while loads miss continuously (port busy) → stall_o=1 on the fifth; accepted once the loads stop and one drain completes; SRAM matches store order.
- flush_i=1 with 3 entries and a store request → stall_o=1; 3 mem_we_o pulses in 3 cycles; empty_o=1; the store is then accepted after flush_i drops.
- rst=0 with 2 entries buffered → mem_we_o=0 during reset; afterwards empty_o=1 and SRAM is unchanged; a load returns the old SRAM value.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory store buffer.
package dmem_pkg;

  localparam int XLEN      = 64;
  localparam int SB_DEPTH  = 4;
  localparam int SB_MEM_AW = 6;

  typedef struct packed {
    logic                 valid;
    logic [SB_MEM_AW-1:0] widx;
    logic [XLEN-1:0]      data;
  } sb_entry_t;

  function automatic logic [SB_MEM_AW-1:0] word_idx(
    input logic [63:0] addr
  );
    return SB_MEM_AW'(addr >> 3);
  endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match search over the store buffer entries.
// Walks from head toward tail so the last hit seen is the youngest.
module sb_fwd_match #(
  parameter  int DEPTH = 4,
  parameter  int AW    = 6,
  parameter  int DW    = 64,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]         valid_i,
  input  logic [DEPTH-1:0][AW-1:0] widx_i,
  input  logic [DEPTH-1:0][DW-1:0] data_i,
  input  logic [PW-1:0]            head_i,
  input  logic [AW-1:0]            key_i,
  output logic                     hit_o,
  output logic [PW-1:0]            idx_o,
  output logic [DW-1:0]            data_o
);

  logic [PW-1:0] pos;

  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    pos   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      pos = head_i + PW'(k);
      if (valid_i[pos] && (widx_i[pos] == key_i)) begin
        hit_o = 1'b1;
        idx_o = pos;
      end
    end
  end

  assign data_o = data_i[idx_o];

endmodule

// File: rtl/dmem_store_buffer.sv
// Store buffer between core data port and a 64-bit-word SRAM.
// Define STBUF_COALESCE_EN to merge stores to an already-buffered word.
module dmem_store_buffer
  import dmem_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int XLEN   = dmem_pkg::XLEN,
  parameter int MEM_AW = SB_MEM_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [63:0]       addrData_DMEM,
  input  logic [XLEN-1:0]   wrData_DMEM,
  input  logic              MemWrite_DMEM,
  input  logic              MemRead_DMEM,
  output logic [XLEN-1:0]   readData_DMEM,
  output logic              stall_o,
  input  logic              flush_i,
  output logic              empty_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  output logic              mem_we_o,
  input  logic [XLEN-1:0]   mem_rdata_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0][MEM_AW-1:0] widx_q, widx_d;
  logic [DEPTH-1:0][XLEN-1:0]   data_q, data_d;
  logic [PW-1:0]                head_q, head_d;
  logic [PW-1:0]                tail_q, tail_d;
  logic [CW-1:0]                count_q, count_d;

  logic [MEM_AW-1:0] req_widx;
  logic              fwd_hit, hit_g;
  logic [PW-1:0]     fwd_idx;
  logic [XLEN-1:0]   fwd_data;
  logic              full, nonempty, ld_miss;
  logic              drain, alloc, coal;

  logic unused_addr;
  assign unused_addr = ^{addrData_DMEM[63:MEM_AW+3],
                         addrData_DMEM[2:0]};

  assign req_widx = addrData_DMEM[MEM_AW+2:3];

  sb_fwd_match #(
    .DEPTH(DEPTH),
    .AW   (MEM_AW),
    .DW   (XLEN)
  ) u_fwd (
    .valid_i(valid_q),
    .widx_i (widx_q),
    .data_i (data_q),
    .head_i (head_q),
    .key_i  (req_widx),
    .hit_o  (fwd_hit),
    .idx_o  (fwd_idx),
    .data_o (fwd_data)
  );

  assign full     = (count_q == CW'(DEPTH));
  assign nonempty = (count_q != '0);
  assign hit_g    = rst & fwd_hit;
  // A load that misses the buffer owns the single SRAM port.
  assign ld_miss  = MemRead_DMEM & ~hit_g;
  assign drain    = rst & nonempty & ~ld_miss;

`ifdef STBUF_COALESCE_EN
  assign coal  = rst & MemWrite_DMEM & ~flush_i & fwd_hit
               & ~(drain & (fwd_idx == head_q));
  assign alloc = rst & MemWrite_DMEM & ~flush_i & ~coal & ~full;
`else
  logic unused_idx;
  assign unused_idx = ^fwd_idx;
  assign coal  = 1'b0;
  assign alloc = rst & MemWrite_DMEM & ~flush_i & ~full;
`endif

  assign stall_o = rst & MemWrite_DMEM & ~coal & (full | flush_i);
  assign empty_o = ~rst | ~nonempty;
  assign readData_DMEM = hit_g ? fwd_data : mem_rdata_i;

  assign mem_we_o    = drain;
  assign mem_wdata_o = data_q[head_q];

  always_comb begin
    if (ld_miss)       mem_addr_o = req_widx;
    else if (nonempty) mem_addr_o = widx_q[head_q];
    else               mem_addr_o = '0;
  end

  always_comb begin
    valid_d = valid_q;
    widx_d  = widx_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (drain) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
    end
    if (alloc) begin
      valid_d[tail_q] = 1'b1;
      widx_d[tail_q]  = req_widx;
      data_d[tail_q]  = wrData_DMEM;
      tail_d          = tail_q + PW'(1);
    end
    if (coal) begin
      data_d[fwd_idx] = wrData_DMEM;
    end
    count_d = count_q + CW'(alloc) - CW'(drain);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      widx_q  <= '0;
      data_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      widx_q  <= widx_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for dmem_store_buffer with a behavioural SRAM.
// SRAM word i starts as 0xA000+i.
module tb_dmem_store_buffer;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] addrData_DMEM;
  logic [63:0] wrData_DMEM;
  logic        MemWrite_DMEM;
  logic        MemRead_DMEM;
  logic [63:0] readData_DMEM;
  logic        stall_o;
  logic        flush_i;
  logic        empty_o;
  logic [5:0]  mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic        mem_we_o;
  logic [63:0] mem_rdata_i;

  logic [63:0] sram [64];
  logic        sram_init;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  dmem_store_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .addrData_DMEM(addrData_DMEM),
    .wrData_DMEM  (wrData_DMEM),
    .MemWrite_DMEM(MemWrite_DMEM),
    .MemRead_DMEM (MemRead_DMEM),
    .readData_DMEM(readData_DMEM),
    .stall_o      (stall_o),
    .flush_i      (flush_i),
    .empty_o      (empty_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_we_o     (mem_we_o),
    .mem_rdata_i  (mem_rdata_i)
  );

  always @(posedge clk) begin
    if (sram_init) begin
      for (int i = 0; i < 64; i++) sram[i] <= 64'hA000 + 64'(i);
    end else if (mem_we_o) begin
      sram[mem_addr_o] <= mem_wdata_o;
    end
  end

  assign mem_rdata_i = sram[mem_addr_o];

  task automatic setin(input logic w, input logic r,
                       input logic [63:0] a, input logic [63:0] d,
                       input logic f);
    MemWrite_DMEM = w;
    MemRead_DMEM  = r;
    addrData_DMEM = a;
    wrData_DMEM   = d;
    flush_i       = f;
  endtask

  task automatic test_reset;
    sram_init = 1'b1;
    rst = 1'b0;
    setin(0, 0, 64'h0, 64'h0, 0);
    repeat (2) @(negedge clk);
    sram_init = 1'b0;
    setin(1, 1, 64'h18, 64'h55, 1);
    #1;
    n_tests++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %0b exp 0", stall_o); end
    n_tests++; if (mem_we_o !== 1'b0) begin n_fail++; $display("FAIL rst_we got %0b exp 0", mem_we_o); end
    n_tests++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL rst_empty got %0b exp 1", empty_o); end
    n_tests++; if (readData_DMEM !== 64'hA003) begin n_fail++; $display("FAIL rst_rdata got %h exp a003", readData_DMEM); end
    @(negedge clk);
    rst = 1'b1;
    setin(0, 0, 64'h0, 64'h0, 0);
    #1;
    n_tests++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL rst_empty2 got %0b exp 1", empty_o); end
    n_tests++; if (mem_addr_o !== 6'd0) begin n_fail++; $display("FAIL rst_idle_addr got %0d exp 0", mem_addr_o); end
  endtask

  task automatic test_store_drain;
    @(negedge clk);
    setin(1, 0, 64'h0, 64'h8, 0);
    #1;
    n_tests++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL sd_stall got %0b exp 0", stall_o); end
    @(negedge clk);
    setin(0, 0, 64'h0, 64'h0, 0);
    #1;
    n_tests++; if (empty_o !== 1'b0) begin n_fail++; $display("FAIL sd_nonempty got %0b exp 0", empty_o); end
    n_tests++; if (mem_we_o !== 1'b1) begin n_fail++; $display("FAIL sd_we got %0b exp 1", mem_we_o); end
    n_tests++; if (mem_addr_o !== 6'd0) begin n_fail++; $display("FAIL sd_addr got %0d exp 0", mem_addr_o); end
    n_tests++; if (mem_wdata_o !== 64'h8) begin n_fail++; $display("FAIL sd_wdata got %h exp 8", mem_wdata_o); end
    @(negedge clk);
    #1;
    n_tests++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL sd_empty got %0b exp 1", empty_o); end
    n_tests++; if (sram[0] !== 64'h8) begin n_fail++; $display("FAIL sd_sram got %h exp 8", sram[0]); end
  endtask

  task automatic test_forward;
    @(negedge clk);
    setin(1, 0, 64'h8, 64'h8, 0);
    @(negedge clk);
    setin(0, 1, 64'h8, 64'h0, 0);
    #1;
    n_tests++; if (readData_DMEM !== 64'h8) begin n_fail++; $display("FAIL fw_rdata got %h exp 8", readData_DMEM); end
    n_tests++; if (mem_we_o !== 1'b1) begin n_fail++; $display("FAIL fw_we got %0b exp 1", mem_we_o); end
    n_tests++; if (mem_addr_o !== word_idx(64'h8)) begin n_fail++; $display("FAIL fw_addr got %0d exp 1", mem_addr_o); end
    @(negedge clk);
    setin(0, 0, 64'h0, 64'h0, 0);
    #1;
    n_tests++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL fw_empty got %0b exp 1", empty_o); end
    n_tests++; if (sram[1] !== 64'h8) begin n_fail++; $display("FAIL fw_sram got %h exp 8", sram[1]); end
  endtask

  task automatic test_youngest;
    @(negedge clk);
    setin(1, 0, 64'h18, 64'h33, 0);
    @(negedge clk);
    setin(1, 1, 64'h10, 64'h11, 0);
    #1;
    n_tests++; if (readData_DMEM !== 64'hA002) begin n_fail++; $display("FAIL yg_miss got %h exp a002", readData_DMEM); end
    n_tests++; if (mem_we_o !== 1'b0) begin n_fail++; $display("FAIL yg_busy_we got %0b exp 0", mem_we_o); end
    n_tests++; if (mem_addr_o !== 6'd2) begin n_fail++; $display("FAIL yg_ld_addr got %0d exp 2", mem_addr_o); end
    @(negedge clk);
    setin(1, 1, 64'h10, 64'h22, 0);
    #1;
    n_tests++; if (readData_DMEM !== 64'h11) begin n_fail++; $display("FAIL yg_rw_old got %h exp 11", readData_DMEM); end
    n_tests++; if (mem_wdata_o !== 64'h33 || mem_we_o !== 1'b1) begin n_fail++; $display("FAIL yg_drain0 got %h/%0b exp 33/1", mem_wdata_o, mem_we_o); end
    @(negedge clk);
    setin(0, 1, 64'h10, 64'h0, 0);
    #1;
    n_tests++; if (readData_DMEM !== 64'h22) begin n_fail++; $display("FAIL yg_young got %h exp 22", readData_DMEM); end
    n_tests++; if (mem_wdata_o !== 64'h11 || mem_we_o !== 1'b1) begin n_fail++; $display("FAIL yg_drain1 got %h/%0b exp 11/1", mem_wdata_o, mem_we_o); end
    @(negedge clk);
    setin(0, 0, 64'h0, 64'h0, 0);
    #1;
    n_tests++; if (mem_wdata_o !== 64'h22 || mem_we_o !== 1'b1) begin n_fail++; $display("FAIL yg_drain2 got %h/%0b exp 22/1", mem_wdata_o, mem_we_o); end
    @(negedge clk);
    #1;
    n_tests++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL yg_empty got %0b exp 1", empty_o); end
    n_tests++; if (sram[2] !== 64'h22 || sram[3] !== 64'h33) begin n_fail++; $display("FAIL yg_sram got %h/%h exp 22/33", sram[2], sram[3]); end
  endtask

  task automatic test_full_stall;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      setin(1, 1, 64'((8 + k) * 8), 64'h100 + 64'(k), 0);
      #1;
      n_tests++; if (stall_o !== 1'b0 || mem_we_o !== 1'b0) begin n_fail++; $display("FAIL fs_fill%0d got %0b/%0b exp 0/0", k, stall_o, mem_we_o); end
      n_tests++; if (readData_DMEM !== 64'hA008 + 64'(k)) begin n_fail++; $display("FAIL fs_rd%0d got %h exp %h", k, readData_DMEM, 64'hA008 + 64'(k)); end
    end
    @(negedge clk);
    setin(1, 1, 64'h60, 64'h104, 0);
    #1;
    n_tests++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL fs_stall5 got %0b exp 1", stall_o); end
    n_tests++; if (mem_we_o !== 1'b0) begin n_fail++; $display("FAIL fs_busy got %0b exp 0", mem_we_o); end
    @(negedge clk);
    setin(1, 0, 64'h60, 64'h104, 0);
    #1;
    n_tests++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL fs_stall_drain got %0b exp 1", stall_o); end
    n_tests++; if (mem_we_o !== 1'b1 || mem_wdata_o !== 64'h100 || mem_addr_o !== 6'd8) begin n_fail++; $display("FAIL fs_d0 got %0b/%h/%0d exp 1/100/8", mem_we_o, mem_wdata_o, mem_addr_o); end
    @(negedge clk);
    #1;
    n_tests++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL fs_accept got %0b exp 0", stall_o); end
    n_tests++; if (mem_we_o !== 1'b1 || mem_wdata_o !== 64'h101) begin n_fail++; $display("FAIL fs_d1 got %0b/%h exp 1/101", mem_we_o, mem_wdata_o); end
    for (int k = 2; k < 5; k++) begin
      @(negedge clk);
      setin(0, 0, 64'h0, 64'h0, 0);
      #1;
      n_tests++; if (mem_we_o !== 1'b1 || mem_wdata_o !== 64'h100 + 64'(k) || mem_addr_o !== 6'(8 + k)) begin n_fail++; $display("FAIL fs_d%0d got %0b/%h/%0d", k, mem_we_o, mem_wdata_o, mem_addr_o); end
    end
    @(negedge clk);
    #1;
    n_tests++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL fs_empty got %0b exp 1", empty_o); end
    for (int k = 0; k < 5; k++) begin
      n_tests++; if (sram[8 + k] !== 64'h100 + 64'(k)) begin n_fail++; $display("FAIL fs_sram%0d got %h exp %h", k, sram[8 + k], 64'h100 + 64'(k)); end
    end
  endtask

  task automatic test_flush;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      setin(1, 1, 64'((16 + k) * 8), 64'h200 + 64'(k), 0);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      setin(1, 0, 64'h98, 64'h2FF, 1);
      #1;
      n_tests++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL fl_stall%0d got %0b exp 1", k, stall_o); end
      n_tests++; if (mem_we_o !== 1'b1 || mem_wdata_o !== 64'h200 + 64'(k) || mem_addr_o !== 6'(16 + k)) begin n_fail++; $display("FAIL fl_d%0d got %0b/%h/%0d", k, mem_we_o, mem_wdata_o, mem_addr_o); end
    end
    @(negedge clk);
    setin(1, 0, 64'h98, 64'h2FF, 0);
    #1;
    n_tests++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL fl_empty got %0b exp 1", empty_o); end
    n_tests++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL fl_accept got %0b exp 0", stall_o); end
    @(negedge clk);
    setin(0, 0, 64'h0, 64'h0, 0);
    #1;
    n_tests++; if (mem_we_o !== 1'b1 || mem_wdata_o !== 64'h2FF || mem_addr_o !== 6'd19) begin n_fail++; $display("FAIL fl_post got %0b/%h/%0d exp 1/2ff/19", mem_we_o, mem_wdata_o, mem_addr_o); end
    @(negedge clk);
    #1;
    n_tests++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL fl_empty2 got %0b exp 1", empty_o); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    setin(1, 1, 64'hA0, 64'h300, 0);
    @(negedge clk);
    setin(1, 1, 64'hA8, 64'h301, 0);
    @(negedge clk);
    rst = 1'b0;
    setin(0, 0, 64'h0, 64'h0, 0);
    #1;
    n_tests++; if (mem_we_o !== 1'b0) begin n_fail++; $display("FAIL rm_we got %0b exp 0", mem_we_o); end
    n_tests++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL rm_empty_rst got %0b exp 1", empty_o); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++; if (empty_o !== 1'b1 || mem_we_o !== 1'b0) begin n_fail++; $display("FAIL rm_after got %0b/%0b exp 1/0", empty_o, mem_we_o); end
    @(negedge clk);
    setin(0, 1, 64'hA0, 64'h0, 0);
    #1;
    n_tests++; if (readData_DMEM !== 64'hA014) begin n_fail++; $display("FAIL rm_old0 got %h exp a014", readData_DMEM); end
    @(negedge clk);
    setin(0, 1, 64'hA8, 64'h0, 0);
    #1;
    n_tests++; if (readData_DMEM !== 64'hA015) begin n_fail++; $display("FAIL rm_old1 got %h exp a015", readData_DMEM); end
  endtask

  initial begin
    sram_init = 1'b1;
    rst = 1'b0;
    setin(0, 0, 64'h0, 64'h0, 0);
    test_reset;
    test_store_drain;
    test_forward;
    test_youngest;
    test_full_stall;
    test_flush;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
